// File: rtl/prefetch_fetch.sv
// Instruction fetch with a small prefetch queue in front of the IF/ID register.
// Optional macro FETCH_BYPASS_EN: an empty queue forwards the fetched word straight into IF/ID.
module prefetch_fetch #(
  parameter int unsigned IMEM_DEPTH  = 1024,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               branch_taken,
  input  logic [31:0]                        branch_addr,
  input  logic                               pc_write,
  input  logic                               ifid_write,
  input  logic                               imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0]      imem_waddr,
  input  logic [31:0]                        imem_wdata,
  output logic [31:0]                        ifid_pc_plus_four,
  output logic [31:0]                        ifid_instruction,
  output logic                               ifid_valid,
  output logic [$clog2(QUEUE_DEPTH):0]       queue_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned QW = $clog2(QUEUE_DEPTH);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] ins;
  } entry_t;

  logic [31:0] imem [IMEM_DEPTH];
  entry_t      queue [QUEUE_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [QW-1:0] head_q, head_d, tail_q, tail_d;
  logic [QW:0] count_q, count_d;
  entry_t ifid_q, ifid_d;
  logic valid_q, valid_d;

  logic [31:0] fetch_ins, pc_plus_four;
  logic empty, full, pop, push, bypass, enq;

  // Combinational fetch; addresses beyond the memory read as zero.
  always_comb begin
    fetch_ins    = imem[pc_q[AW+1:2]];
    if ((pc_q >> (AW + 2)) != 32'd0) fetch_ins = 32'h0;
    pc_plus_four = pc_q + 32'd4;
  end

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == (QW+1)'(QUEUE_DEPTH));
    pop   = ifid_write & ~flush & ~empty;
    push  = pc_write & ~branch_taken & ~flush & (~full | pop);
`ifdef FETCH_BYPASS_EN
    bypass = empty & push & ifid_write;
`else
    bypass = 1'b0;
`endif
    enq = push & ~bypass;
  end

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ifid_d  = ifid_q;
    valid_d = valid_q;

    if (branch_taken)  pc_d = branch_addr;
    else if (push)     pc_d = pc_plus_four;

    if (flush | branch_taken) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + QW'(1);
      if (pop) head_d = head_q + QW'(1);
      count_d = count_q + (QW+1)'(enq) - (QW+1)'(pop);
    end

    // Branch alone still lets decode take the pre-clear head.
    if (flush) begin
      ifid_d  = '0;
      valid_d = 1'b0;
    end else if (ifid_write) begin
      if (bypass) begin
        ifid_d  = '{pc4: pc_plus_four, ins: fetch_ins};
        valid_d = 1'b1;
      end else if (pop) begin
        ifid_d  = queue[head_q];
        valid_d = 1'b1;
      end else begin
        ifid_d  = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ifid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
    if (enq)     queue[tail_q] <= '{pc4: pc_plus_four, ins: fetch_ins};
  end

  assign ifid_pc_plus_four = ifid_q.pc4;
  assign ifid_instruction  = ifid_q.ins;
  assign ifid_valid        = valid_q;
  assign queue_count       = count_q;

endmodule

// File: tb/tb_prefetch_fetch.sv
// Directed vector bench for prefetch_fetch (default parameters).
module tb_prefetch_fetch;

  logic        clk, rst_n, flush, branch_taken, pc_write, ifid_write, imem_we;
  logic [31:0] branch_addr, imem_wdata;
  logic [9:0]  imem_waddr;
  logic [31:0] ifid_pc_plus_four, ifid_instruction;
  logic        ifid_valid;
  logic [2:0]  queue_count;

  int n_cmp = 0;
  int n_err = 0;

  prefetch_fetch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .pc_write(pc_write), .ifid_write(ifid_write),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .ifid_pc_plus_four(ifid_pc_plus_four), .ifid_instruction(ifid_instruction),
    .ifid_valid(ifid_valid), .queue_count(queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pcw, ifw, br, fl;
    logic [31:0] baddr;
    logic [31:0] e_pc4, e_ins;
    logic        e_v;
    logic [2:0]  e_cnt;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] w(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic vec_t mk(input logic pcw, ifw, br, fl, input logic [31:0] baddr,
                              input logic [31:0] e_pc4, e_ins, input logic e_v,
                              input logic [2:0] e_cnt, input logic [31:0] e_pc);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.br = br; v.fl = fl; v.baddr = baddr;
    v.e_pc4 = e_pc4; v.e_ins = e_ins; v.e_v = e_v; v.e_cnt = e_cnt; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pcw, ifw, br, fl, input logic [31:0] baddr);
    pc_write = pcw; ifid_write = ifw; branch_taken = br; flush = fl; branch_addr = baddr;
  endtask

  // Holds reset for one edge, then releases between edges so the next edge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      drive(tbl[i].pcw, tbl[i].ifw, tbl[i].br, tbl[i].fl, tbl[i].baddr);
      step();
      check($sformatf("%s%0d pc4", tag, i), ifid_pc_plus_four, tbl[i].e_pc4);
      check($sformatf("%s%0d ins", tag, i), ifid_instruction, tbl[i].e_ins);
      check($sformatf("%s%0d valid", tag, i), 32'(ifid_valid), 32'(tbl[i].e_v));
      check($sformatf("%s%0d count", tag, i), 32'(queue_count), 32'(tbl[i].e_cnt));
      check($sformatf("%s%0d pc", tag, i), dut.pc_q, tbl[i].e_pc);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("reset count", 32'(queue_count), 32'd0);
    check("reset valid", 32'(ifid_valid), 32'd0);
    check("reset ins", ifid_instruction, 32'd0);
    check("reset pc4", ifid_pc_plus_four, 32'd0);
    check("reset pc", dut.pc_q, 32'h0);

    for (int i = 0; i < 64; i++) begin
      imem_we = 1'b1; imem_waddr = 10'(i); imem_wdata = w(i);
      step();
    end
    imem_we = 1'b0;

    // Main sequence from reset release with all enables high.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    do_reset();
`ifdef FETCH_BYPASS_EN
    tbl.push_back(mk(1,1,0,0,0,   32'h4,  w(0), 1, 0, 32'h4));
    tbl.push_back(mk(1,1,0,0,0,   32'h8,  w(1), 1, 0, 32'h8));
    tbl.push_back(mk(1,0,0,0,0,   32'h8,  w(1), 1, 1, 32'hC));
    tbl.push_back(mk(1,1,0,0,0,   32'hC,  w(2), 1, 1, 32'h10));
    tbl.push_back(mk(1,1,1,1,32'h40, 32'h0, 32'h0, 0, 0, 32'h40));
    tbl.push_back(mk(1,1,0,0,0,   32'h44, w(16), 1, 0, 32'h44));
`else
    tbl.push_back(mk(1,1,0,0,0,   32'h0,  32'h0, 0, 1, 32'h4));
    tbl.push_back(mk(1,1,0,0,0,   32'h4,  w(0),  1, 1, 32'h8));
    tbl.push_back(mk(1,1,0,0,0,   32'h8,  w(1),  1, 1, 32'hC));
    tbl.push_back(mk(1,1,0,0,0,   32'hC,  w(2),  1, 1, 32'h10));
    tbl.push_back(mk(1,1,0,0,0,   32'h10, w(3),  1, 1, 32'h14));
    tbl.push_back(mk(1,1,1,1,32'h40, 32'h0, 32'h0, 0, 0, 32'h40));
    tbl.push_back(mk(1,1,0,0,0,   32'h0,  32'h0, 0, 1, 32'h44));
    tbl.push_back(mk(1,1,0,0,0,   32'h44, w(16), 1, 1, 32'h48));
    tbl.push_back(mk(1,1,1,0,32'h80, 32'h48, w(17), 1, 0, 32'h80));
    tbl.push_back(mk(1,1,0,0,0,   32'h0,  32'h0, 0, 1, 32'h84));
    tbl.push_back(mk(1,1,0,0,0,   32'h84, w(32), 1, 1, 32'h88));
    tbl.push_back(mk(1,0,0,0,0,   32'h84, w(32), 1, 2, 32'h8C));
    tbl.push_back(mk(1,0,0,0,0,   32'h84, w(32), 1, 3, 32'h90));
    tbl.push_back(mk(1,0,0,0,0,   32'h84, w(32), 1, 4, 32'h94));
    tbl.push_back(mk(1,0,0,0,0,   32'h84, w(32), 1, 4, 32'h94));
    tbl.push_back(mk(1,1,0,0,0,   32'h88, w(33), 1, 4, 32'h98));
    tbl.push_back(mk(0,1,0,0,0,   32'h8C, w(34), 1, 3, 32'h98));
    tbl.push_back(mk(1,0,0,1,0,   32'h0,  32'h0, 0, 0, 32'h98));
`endif
    run_table("vec");

    // Decode stalled for 6 cycles from reset: queue saturates, PC stops at 16.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("sat count", 32'(queue_count), 32'd4);
    check("sat pc", dut.pc_q, 32'h10);
    check("sat valid", 32'(ifid_valid), 32'd0);
    check("sat ins", ifid_instruction, 32'd0);

    // Async reset with three entries queued.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check("pre-rst count", 32'(queue_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async count", 32'(queue_count), 32'd0);
    check("async valid", 32'(ifid_valid), 32'd0);
    check("async pc", dut.pc_q, 32'h0);
    rst_n = 1'b1;
    step();

    // Top-of-address-space fetch: out of range reads zero and PC wraps.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    step();
    check("wrap br pc", dut.pc_q, 32'hFFFF_FFFC);
    check("wrap br count", 32'(queue_count), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("wrap pc", dut.pc_q, 32'h0);
    check("wrap count", 32'(queue_count), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("wrap valid", 32'(ifid_valid), 32'd1);
    check("wrap ins", ifid_instruction, 32'h0);
    check("wrap pc4", ifid_pc_plus_four, 32'h0);

    // Write to the word being fetched in the same cycle: queue gets the old word.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h14);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    imem_we = 1'b1; imem_waddr = 10'd5; imem_wdata = 32'hDEAD_BEEF;
    step();
    imem_we = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
`ifndef FETCH_BYPASS_EN
    step();
`endif
    check("rdw ins", ifid_instruction, w(5));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h14);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("rdw new ins", ifid_instruction, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
